// File: rtl/tlcd_bus_arbiter.sv
// tlcd_bus_arbiter: round-robin owner of the shared character-LCD bus with E-low guard periods and hold timeout
module tlcd_bus_arbiter #(
  parameter int NREQ      = 3,
  parameter int GUARD_CYC = 2,
  parameter int MAX_HOLD  = 500000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   E_IN,
  input  logic [NREQ-1:0]   RS_IN,
  input  logic [NREQ-1:0]   RW_IN,
  input  logic [8*NREQ-1:0] DATA_IN,
  output logic [NREQ-1:0]   GNT,
  output logic              TLCD_E,
  output logic              TLCD_RS,
  output logic              TLCD_RW,
  output logic [7:0]        TLCD_DATA,
  output logic [1:0]        OWNER,
  output logic              BUSY,
  output logic              TIMEOUT
);
  typedef enum logic [1:0] {IDLE, GUARD, GRANT, DRAIN} state_t;
  localparam logic [15:0] GLAST = 16'(GUARD_CYC - 1);
  localparam logic [19:0] HLAST = 20'(MAX_HOLD - 1);
  localparam logic [19:0] HMAX  = '1;
  state_t state;
  logic [1:0] ptr, win;
  logic found;
  logic [NREQ-1:0] mask, elig, own_hot;
  logic [15:0] gcnt;
  logic [19:0] hold;
  logic own_req, own_e, own_rs, own_rw;
  logic [7:0] own_data;
  // round-robin pick among eligible requesters, starting just after the last owner
  always_comb begin
    elig = REQ & ~mask;
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && elig[(int'(ptr) + i) % NREQ]) begin
        win = 2'((int'(ptr) + i) % NREQ);
        found = 1'b1;
      end
  end
  // select the current owner's bus signals; everyone else is ignored
  always_comb begin
    own_req = 1'b0;
    own_e = 1'b0;
    own_rs = 1'b0;
    own_rw = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (OWNER == 2'(i)) begin
        own_req = REQ[i];
        own_e = E_IN[i];
        own_rs = RS_IN[i];
        own_rw = RW_IN[i];
        own_data = DATA_IN[8*i +: 8];
      end
    own_hot = NREQ'(1) << OWNER;
  end
  // ownership FSM: IDLE -> GUARD -> GRANT -> DRAIN, all outputs registered
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state <= IDLE;
      GNT <= '0;
      TLCD_E <= 1'b0;
      TLCD_RS <= 1'b0;
      TLCD_RW <= 1'b0;
      TLCD_DATA <= '0;
      OWNER <= '0;
      BUSY <= 1'b0;
      TIMEOUT <= 1'b0;
      ptr <= 2'(NREQ - 1);
      mask <= '0;
      gcnt <= '0;
      hold <= '0;
    end else begin
      TIMEOUT <= 1'b0;
      mask <= mask & REQ;
      case (state)
        IDLE:
          if (found) begin
            state <= GUARD;
            OWNER <= win;
            BUSY <= 1'b1;
            gcnt <= '0;
          end
        GUARD:
          if (!own_req) begin
            state <= IDLE;
            BUSY <= 1'b0;
          end else if (gcnt == GLAST) begin
            state <= GRANT;
            GNT <= own_hot;
            ptr <= OWNER;
            hold <= '0;
          end else gcnt <= gcnt + 16'd1;
        GRANT:
          if (!own_req) begin
            state <= DRAIN;
            GNT <= '0;
            TLCD_E <= 1'b0;
            gcnt <= '0;
          end else if (MAX_HOLD != 0 && hold == HLAST) begin
            state <= DRAIN;
            GNT <= '0;
            TLCD_E <= 1'b0;
            gcnt <= '0;
            TIMEOUT <= 1'b1;
            mask <= (mask & REQ) | own_hot;
          end else begin
            TLCD_E <= own_e;
            TLCD_RS <= own_rs;
            TLCD_RW <= own_rw;
            TLCD_DATA <= own_data;
            hold <= hold == HMAX ? hold : hold + 20'd1;
          end
        DRAIN:
          if (gcnt == GLAST) begin
            state <= IDLE;
            BUSY <= 1'b0;
          end else gcnt <= gcnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// tb_tlcd_bus_arbiter: directed checks of grant order, guards, release, timeout, abort and async reset
module tb_tlcd_bus_arbiter;
  logic CLK = 1'b0, RESETN = 1'b0;
  logic [2:0] REQ = '0, E_IN = '0, RS_IN = '0, RW_IN = '0;
  logic [23:0] DATA_IN = '0;
  logic [2:0] GNT;
  logic TLCD_E, TLCD_RS, TLCD_RW, BUSY, TIMEOUT;
  logic [7:0] TLCD_DATA;
  logic [1:0] OWNER;
  int checks = 0, errors = 0;
  int run = 0, min_gap = 1000;
  bit seen = 0, mon = 0, multi = 0;
  int order [4] = '{0, 1, 2, 0};

  tlcd_bus_arbiter #(.NREQ(3), .GUARD_CYC(2), .MAX_HOLD(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .E_IN(E_IN), .RS_IN(RS_IN), .RW_IN(RW_IN),
    .DATA_IN(DATA_IN), .GNT(GNT), .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW),
    .TLCD_DATA(TLCD_DATA), .OWNER(OWNER), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // watch for multi-hot grants and the shortest E-low gap between E-high bursts
  always @(negedge CLK) begin
    if ($countones(GNT) > 1) multi = 1;
    if (mon) begin
      if (TLCD_E) begin
        if (seen && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen = 1;
      end else run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [2:0] exp);
    int k = 0;
    while (GNT == 0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, GNT, exp);
  endtask

  initial begin
    tick(2);
    chk("rst_gnt", GNT, 0);
    chk("rst_e", TLCD_E, 0);
    chk("rst_data", TLCD_DATA, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_timeout", TIMEOUT, 0);
    RESETN = 1;
    REQ = 3'b001;
    tick();
    chk("g1_busy", BUSY, 1);
    chk("g1_gnt_a", GNT, 0);
    tick();
    chk("g1_gnt_b", GNT, 0);
    tick();
    chk("g1_gnt", GNT, 3'b001);
    chk("g1_e_guard", TLCD_E, 0);
    E_IN[0] = 1;
    DATA_IN[7:0] = 8'h41;
    tick();
    chk("g1_e", TLCD_E, 1);
    chk("g1_data", TLCD_DATA, 8'h41);
    REQ = 0;
    tick();
    chk("g1_rel_gnt", GNT, 0);
    chk("g1_rel_e", TLCD_E, 0);
    chk("g1_rel_data", TLCD_DATA, 8'h41);
    chk("g1_rel_to", TIMEOUT, 0);
    tick();
    chk("g1_drain", BUSY, 1);
    tick();
    chk("g1_idle", BUSY, 0);
    E_IN = 0;
    DATA_IN = 0;
    RESETN = 0;
    tick();
    RESETN = 1;
    mon = 1;
    REQ = 3'b111;
    for (int j = 0; j < 4; j++) begin
      wait_gnt("rr_order", 3'(1 << order[j]));
      E_IN[order[j]] = 1;
      tick(5);
      REQ[order[j]] = 0;
      E_IN[order[j]] = 0;
      tick();
      chk("rr_rel_gnt", GNT, 0);
      chk("rr_rel_e", TLCD_E, 0);
      if (j < 3) REQ[order[j]] = 1;
    end
    REQ = 0;
    tick(3);
    mon = 0;
    chk("rr_egap_ge5", 32'(min_gap >= 5 && min_gap < 1000), 1);
    REQ = 3'b010;
    wait_gnt("o1_gnt", 3'b010);
    E_IN[1] = 1;
    RS_IN[1] = 1;
    DATA_IN[15:8] = 8'h5A;
    DATA_IN[7:0] = 8'hFF;
    tick();
    chk("o1_e", TLCD_E, 1);
    chk("o1_data", TLCD_DATA, 8'h5A);
    chk("o1_rs", TLCD_RS, 1);
    REQ = 0;
    tick();
    chk("o1_rel_gnt", GNT, 0);
    chk("o1_rel_e", TLCD_E, 0);
    chk("o1_rel_data", TLCD_DATA, 8'h5A);
    chk("o1_rel_rs", TLCD_RS, 1);
    tick();
    chk("o1_drain", BUSY, 1);
    tick();
    chk("o1_idle", BUSY, 0);
    chk("o1_owner", OWNER, 1);
    E_IN = 0;
    RS_IN = 0;
    DATA_IN = 0;
    REQ = 3'b001;
    wait_gnt("to_gnt0", 3'b001);
    REQ[2] = 1;
    tick(7);
    chk("to_pre", TIMEOUT, 0);
    chk("to_pre_gnt", GNT, 3'b001);
    tick();
    chk("to_pulse", TIMEOUT, 1);
    chk("to_gnt_drop", GNT, 0);
    chk("to_busy", BUSY, 1);
    tick();
    chk("to_pulse_end", TIMEOUT, 0);
    wait_gnt("to_gnt2", 3'b100);
    chk("to_owner2", OWNER, 2);
    REQ[2] = 0;
    tick(12);
    chk("to_masked", GNT, 0);
    chk("to_masked_busy", BUSY, 0);
    REQ[0] = 0;
    tick();
    REQ[0] = 1;
    wait_gnt("to_unmask", 3'b001);
    REQ = 0;
    tick(3);
    REQ = 3'b100;
    tick();
    chk("ab_busy", BUSY, 1);
    chk("ab_owner", OWNER, 2);
    REQ = 0;
    tick();
    chk("ab_idle", BUSY, 0);
    tick(3);
    chk("ab_gnt", GNT, 0);
    REQ = 3'b011;
    wait_gnt("ab_ptr_kept", 3'b010);
    E_IN[1] = 1;
    tick();
    chk("ar_e", TLCD_E, 1);
    #2 RESETN = 0;
    #1;
    chk("ar_gnt", GNT, 0);
    chk("ar_e0", TLCD_E, 0);
    chk("ar_busy", BUSY, 0);
    chk("ar_owner", OWNER, 0);
    tick();
    RESETN = 1;
    wait_gnt("ar_ptr_rst", 3'b001);
    chk("gnt_onehot", 32'(multi), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlcd_bus_arbiter.md
Name: tlcd_bus_arbiter

Overview:
Owns the shared character-LCD bus (E/RS/RW/DATA) and grants it to one of NREQ requesters (font loader, text controller, future status writer). Requesters use a REQ/GNT handshake. Ownership changes only with guard periods of forced E=0 on both sides. A hold timeout stops a stuck requester from keeping the panel. It replaces the static done-flag mux at top level and sits between the LCD drivers and the TLCD pins.

Parameters:
NREQ, 3, number of requesters (2..4)
GUARD_CYC, 2, E-low guard cycles before each grant and after each release (>=1)
MAX_HOLD, 500000, max GRANT cycles per ownership (0 = timeout disabled; <= 2^20-1)

Ports:
CLK  in  1  system clock, 1 MHz
RESETN  in  1  asynchronous reset, active low
REQ  in  NREQ  per-requester bus request, level
E_IN  in  NREQ  per-requester LCD E
RS_IN  in  NREQ  per-requester LCD RS
RW_IN  in  NREQ  per-requester LCD RW
DATA_IN  in  8*NREQ  per-requester LCD data; requester i on [8i+7:8i]
GNT  out  NREQ  one-hot grant, registered
TLCD_E  out  1  LCD enable to pin
TLCD_RS  out  1  LCD register select to pin
TLCD_RW  out  1  LCD read/write to pin
TLCD_DATA  out  8  LCD data to pin
OWNER  out  2  index of current or last owner
BUSY  out  1  high in GUARD, GRANT and DRAIN
TIMEOUT  out  1  one-cycle pulse when a grant is revoked

Behaviour:
- Reset (RESETN low, asynchronous): state IDLE. GNT=0, TLCD_E/RS/RW=0, TLCD_DATA=8'h00, OWNER=0, BUSY=0, TIMEOUT=0. RR pointer=NREQ-1, so requester 0 wins first. Timeout mask cleared, counters 0.
- All outputs are registered. Resetting mid-grant drops GNT and E at once with no drain.
- States: IDLE, GUARD, GRANT, DRAIN.
- IDLE:
  - Eligible = REQ & ~mask.
  - If any requester is eligible at edge k, pick the winner round-robin, searching from pointer+1 circularly.
  - Go to GUARD, set OWNER=winner, BUSY=1.
- GUARD:
  - Lasts exactly GUARD_CYC cycles with E forced 0.
  - GNT[winner] rises at edge k+GUARD_CYC together with entry to GRANT; the pointer updates to the winner at that edge.
  - If REQ[winner] drops during GUARD: return to IDLE, no grant, pointer unchanged.
- GRANT:
  - Each edge registers the owner's E/RS/RW/DATA onto TLCD_* (1-cycle latency).
  - Non-owner inputs are ignored entirely.
  - The hold counter increments each cycle and saturates at 2^20-1.
- Release: REQ[owner] sampled low at edge m moves GRANT to DRAIN. At edge m: GNT=0, TLCD_E=0, RS/RW/DATA hold their last values.
- Timeout: MAX_HOLD!=0, hold counter reaches MAX_HOLD and REQ[owner] is still high:
  - Go to DRAIN, TIMEOUT=1 for one cycle.
  - Set mask[owner].
  - The bit clears once that requester's REQ is sampled low.
- Release and timeout on the same edge: treat as a normal release, no TIMEOUT, no mask.
- DRAIN:
  - Lasts exactly GUARD_CYC cycles with E=0, then returns to IDLE and BUSY=0.
  - Requests arriving during DRAIN wait for IDLE.
  - Minimum E-low gap between two owners is 2*GUARD_CYC+1 cycles.
- OWNER keeps the last owner's value while IDLE.
- Simultaneous requests: exactly one GNT bit is ever high; the others stay pending without loss.

Test Plan:
- Reset, REQ=3'b001 at edge 10, GUARD_CYC=2 -> GNT=3'b001 at edge 12. Drive E_IN[0]=1, DATA=8'h41 at edge 13 -> TLCD_E=1, TLCD_DATA=8'h41 after edge 13.
- REQ=3'b111 held, each requester releases 5 cycles after its grant -> grant order 0,1,2,0. Between owners TLCD_E=0 for >=5 cycles. GNT never multi-hot.
- Owner 1 granted, drives E_IN[1]=1, drops REQ[1] while E high -> GNT and TLCD_E both 0 at the release edge. DATA holds its last value; IDLE after 2 more cycles.
- MAX_HOLD=8, REQ[0] stuck high, REQ[2] high -> TIMEOUT pulse at the 8th GRANT cycle, then grant to 2. Requester 0 not re-granted until REQ[0] drops and rises again.
- REQ[2] raised, then dropped in the 1st GUARD cycle -> no GNT, back to IDLE. Next REQ=3'b001 -> requester 0 wins (pointer unchanged).
- RESETN low for 1 cycle mid-GRANT with E_IN high -> GNT=0, TLCD_E=0 immediately (asynchronous). After release, REQ=3'b010 -> requester 1 wins only if REQ[0]=0; with REQ=3'b011, requester 0 wins.
